// File: rtl/sw_debounce_if.sv
// Switch-bank bundle: raw switches in, debounced vector and change strobe out.
// Defining SW_DEBOUNCE_EDGE_EN adds the per-bit sw_rise/sw_fall strobes.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_db;
  logic             sw_changed;
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;

  modport master (output sw, input sw_db, sw_changed, sw_rise, sw_fall);
  modport slave  (input sw, output sw_db, sw_changed, sw_rise, sw_fall);
`else
  modport master (output sw, input sw_db, sw_changed);
  modport slave  (input sw, output sw_db, sw_changed);
`endif
endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus per-bit stability counter for a slide-switch bank.
// Optional SW_DEBOUNCE_EDGE_EN adds registered per-bit rise/fall commit strobes.
module sw_debounce #(
  parameter int WIDTH   = 4,
  parameter int CNT_MAX = 100000
) (
  input  logic         clk,
  input  logic         reset,
  sw_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  logic [WIDTH-1:0]            sync1_r;
  logic [WIDTH-1:0]            sync2_r;
  logic [WIDTH-1:0]            db_r;
  logic                        changed_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_next_s;
  logic [WIDTH-1:0]            db_next_s;
  logic [WIDTH-1:0]            commit_s;
  state_e                      state_s [WIDTH];
`ifdef SW_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0]            rise_r;
  logic [WIDTH-1:0]            fall_r;
`endif

  // State register: synchronizer, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r   <= {WIDTH{1'b0}};
      sync2_r   <= {WIDTH{1'b0}};
      db_r      <= {WIDTH{1'b0}};
      changed_r <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
`ifdef SW_DEBOUNCE_EDGE_EN
      rise_r    <= {WIDTH{1'b0}};
      fall_r    <= {WIDTH{1'b0}};
`endif
    end else begin
      sync1_r   <= bus.sw;
      sync2_r   <= sync1_r;
      db_r      <= db_next_s;
      changed_r <= |commit_s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
`ifdef SW_DEBOUNCE_EDGE_EN
      rise_r    <= commit_s & sync2_r;
      fall_r    <= commit_s & ~sync2_r;
`endif
    end
  end

  // Next-state logic: a channel counts while sync2 disagrees with its output,
  // aborts to zero as soon as they agree again, and commits on the last count.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_s[i]    = (sync2_r[i] != db_r[i]) ? ST_COUNT : ST_IDLE;
      cnt_next_s[i] = CNT_ZERO;
      db_next_s[i]  = db_r[i];
      commit_s[i]   = 1'b0;
      case (state_s[i])
        ST_IDLE: begin
          cnt_next_s[i] = CNT_ZERO;
        end
        ST_COUNT: begin
          if (cnt_r[i] == CNT_LAST) begin
            commit_s[i]   = 1'b1;
            db_next_s[i]  = sync2_r[i];
            cnt_next_s[i] = CNT_ZERO;
          end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_next_s[i] = CNT_ZERO;
        end
      endcase
    end
  end

  // Output mapping: every output comes straight from a register.
  always_comb begin
    bus.sw_db      = db_r;
    bus.sw_changed = changed_r;
`ifdef SW_DEBOUNCE_EDGE_EN
    bus.sw_rise    = rise_r;
    bus.sw_fall    = fall_r;
`endif
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Randomized plus directed bench for sw_debounce (WIDTH=4, CNT_MAX=4) against a
// sliding-window reference model; also covers SW_DEBOUNCE_EDGE_EN when defined.
module tb_sw_debounce;

  localparam int WIDTH   = 4;
  localparam int CNT_MAX = 4;
  localparam int DEPTH   = CNT_MAX + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  sw_debounce_if #(.WIDTH(WIDTH)) bus ();

  sw_debounce #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: hist[k] is sw as sampled k edges ago. A bit commits when the last
  // CNT_MAX values that reached the second synchronizer stage all differ from it.
  logic [WIDTH-1:0] hist [DEPTH];
  logic [WIDTH-1:0] m_db      = '0;
  logic [WIDTH-1:0] m_rise    = '0;
  logic [WIDTH-1:0] m_fall    = '0;
  logic [WIDTH-1:0] m_commit  = '0;
  logic             m_changed = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) hist[j] = '0;
      m_db      = '0;
      m_rise    = '0;
      m_fall    = '0;
      m_changed = 1'b0;
    end else begin
      for (int j = DEPTH - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0]  = bus.sw;
      m_commit = '1;
      for (int i = 0; i < WIDTH; i++)
        for (int j = 2; j <= CNT_MAX + 1; j++)
          if (hist[j][i] == m_db[i]) m_commit[i] = 1'b0;
      m_changed = |m_commit;
      m_rise    = m_commit & ~m_db;
      m_fall    = m_commit & m_db;
      m_db      = m_db ^ m_commit;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    vectors++;
    if (bus.sw_db !== m_db) begin
      miscompares++;
      $display("FAIL sw_db t=%0t: got %b expected %b", $time, bus.sw_db, m_db);
    end
    vectors++;
    if (bus.sw_changed !== m_changed) begin
      miscompares++;
      $display("FAIL sw_changed t=%0t: got %b expected %b", $time, bus.sw_changed, m_changed);
    end
`ifdef SW_DEBOUNCE_EDGE_EN
    vectors++;
    if (bus.sw_rise !== m_rise || bus.sw_fall !== m_fall) begin
      miscompares++;
      $display("FAIL rise_fall t=%0t: got %b/%b expected %b/%b",
               $time, bus.sw_rise, bus.sw_fall, m_rise, m_fall);
    end
`endif
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int hold;
  int b;

  initial begin
    bus.sw = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Settle at 1111, then asynchronous reset mid-cycle.
    @(negedge clk);
    bus.sw = 4'b1111;
    tick(6);
    check("pre_reset_db", bus.sw_db, 4'b1111);
    #2 reset = 1'b1;
    #1;
    check("async_reset_db", bus.sw_db, 4'b0000);
    check("async_reset_chg", {3'b000, bus.sw_changed}, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    check("rst_edge5_db", bus.sw_db, 4'b0000);
    tick(1);
    check("rst_edge6_db", bus.sw_db, 4'b1111);
    check("rst_edge6_chg", {3'b000, bus.sw_changed}, 4'b0001);
    tick(1);
    check("rst_edge7_chg", {3'b000, bus.sw_changed}, 4'b0000);

    // Bounce: sw[2] high for only 3 samples.
    bus.sw = 4'b0000;
    pulse_reset();
    tick(2);
    @(negedge clk);
    bus.sw = 4'b0100;
    repeat (3) @(negedge clk);
    bus.sw = 4'b0000;
    tick(8);
    check("bounce_db", bus.sw_db, 4'b0000);
    @(negedge clk);
    bus.sw = 4'b0100;
    tick(5);
    check("bounce_hold5_db", bus.sw_db, 4'b0000);
    tick(1);
    check("bounce_hold6_db", bus.sw_db, 4'b0100);
    check("bounce_hold6_chg", {3'b000, bus.sw_changed}, 4'b0001);

    // Clean change to 0101.
    bus.sw = 4'b0000;
    pulse_reset();
    tick(2);
    @(negedge clk);
    bus.sw = 4'b0101;
    tick(5);
    check("clean5_db", bus.sw_db, 4'b0000);
    tick(1);
    check("clean6_db", bus.sw_db, 4'b0101);
    check("clean6_chg", {3'b000, bus.sw_changed}, 4'b0001);
    tick(1);
    check("clean7_chg", {3'b000, bus.sw_changed}, 4'b0000);

    // Reset after three counting cycles on sw[3].
    bus.sw = 4'b0000;
    pulse_reset();
    tick(2);
    @(negedge clk);
    bus.sw = 4'b1000;
    tick(5);
    #2 reset = 1'b1;
    #1;
    check("midcnt_reset_db", bus.sw_db, 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    tick(5);
    check("midcnt5_db", bus.sw_db, 4'b0000);
    tick(1);
    check("midcnt6_db", bus.sw_db, 4'b1000);

    // Staggered rises on sw[0] then sw[1].
    bus.sw = 4'b0000;
    pulse_reset();
    tick(2);
    @(negedge clk);
    bus.sw = 4'b0001;
    @(negedge clk);
    bus.sw = 4'b0011;
    tick(5);
    check("stag_t5_db", bus.sw_db, 4'b0001);
    check("stag_t5_chg", {3'b000, bus.sw_changed}, 4'b0001);
    tick(1);
    check("stag_t6_db", bus.sw_db, 4'b0011);
    check("stag_t6_chg", {3'b000, bus.sw_changed}, 4'b0001);
    tick(1);
    check("stag_t7_chg", {3'b000, bus.sw_changed}, 4'b0000);

`ifdef SW_DEBOUNCE_EDGE_EN
    // Rise then fall on sw[1].
    bus.sw = 4'b0000;
    pulse_reset();
    tick(2);
    @(negedge clk);
    bus.sw = 4'b0010;
    tick(6);
    check("edge_rise", bus.sw_rise, 4'b0010);
    check("edge_rise_fall", bus.sw_fall, 4'b0000);
    check("edge_rise_chg", {3'b000, bus.sw_changed}, 4'b0001);
    tick(1);
    check("edge_rise_end", bus.sw_rise, 4'b0000);
    @(negedge clk);
    bus.sw = 4'b0000;
    tick(6);
    check("edge_fall", bus.sw_fall, 4'b0010);
    check("edge_fall_rise", bus.sw_rise, 4'b0000);
    check("edge_fall_chg", {3'b000, bus.sw_changed}, 4'b0001);
`endif

    // Randomized holds, bounces and occasional asynchronous resets.
    hold = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      reset = 1'b0;
      if (hold == 0) begin
        bus.sw = WIDTH'($urandom);
        hold   = $urandom_range(1, 12);
      end else if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, WIDTH - 1);
        bus.sw[b] = ~bus.sw[b];
      end
      hold--;
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clk);
    reset = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
